test_checker: RTL
=================

TEST_CHECKER -- requirements
Module: test_checker

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1, number of cores checked.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 SHALL have parameter NUM_REGS, default 32, registers per core (power of two).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100, maximum run cycles before forced scan.
REQ-005 SHALL have ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse starting a test.
- halted  in  NUM_CORES  per-core halt flag, level.
- exp_we  in  1  expected-value write strobe.
- exp_addr  in  log2(NUM_REGS)  expected-table index.
- exp_data  in  DATA_WIDTH  expected value.
- exp_care  in  1  1 = compare this index, 0 = don't care.
- rd_core  out  max(1,log2(NUM_CORES))  core select for register read.
- rd_index  out  log2(NUM_REGS)  register index for read.
- rd_valid  out  1  read request this cycle.
- rd_data  in  DATA_WIDTH  read data, valid exactly one cycle after rd_valid.
- busy  out  1  test in progress.
- done  out  1  result valid, held until next start.
- passed  out  1  all compared registers matched and no timeout.
- timed_out  out  1  TIMEOUT_CYCLES reached before all cores halted.
- fail_count  out  16  mismatch count, saturating at 0xFFFF.
- first_fail_core, first_fail_index, first_fail_exp, first_fail_act  out  rd_core/rd_index/DATA_WIDTH/DATA_WIDTH widths  first mismatch record.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, SCAN, DRAIN, DONE.
REQ-007 IDLE/DONE: start -> RUN next cycle; clear cycle counter, fail_count, first_fail_*, timed_out, passed, done.
REQ-008 RUN: cycle counter increments each cycle; all halted bits 1 -> SCAN; counter reaches TIMEOUT_CYCLES-1 -> set timed_out, SCAN; both true same cycle -> timed_out stays 0.
REQ-009 SCAN: one read per cycle, core-major order (core 0 reg 0 .. core NUM_CORES-1 reg NUM_REGS-1), rd_valid=1; after last request -> DRAIN.
REQ-010 Compare rd_data with expected entry of the request issued one cycle earlier; compare only if exp_care=1 for that index; register 0 always compared against its table entry.
REQ-011 On mismatch: fail_count+1 (saturating); first mismatch only captures core, index, expected, actual.
REQ-012 DRAIN: one cycle for last compare -> DONE; done=1, passed = (fail_count==0) && !timed_out.
REQ-013 Expected table: NUM_REGS entries of DATA_WIDTH+1 bits, shared by all cores, written when exp_we=1 in IDLE or DONE only; writes in RUN/SCAN/DRAIN ignored.
REQ-014 start outside IDLE/DONE SHALL be ignored.
REQ-015 busy=1 in RUN, SCAN, DRAIN; rd_valid=0 outside SCAN.
REQ-016 Latency: all halted at start+1 -> done asserted NUM_CORES*NUM_REGS+3 cycles after start.

Reset
REQ-017 reset low SHALL force IDLE asynchronously; all outputs 0, counters 0, first_fail_* 0, from any state including mid-SCAN.
REQ-018 Expected table contents SHALL reset to value 0 with care=1.

Structure
REQ-019 State encoding and a CLOG2 constant function SHALL live in shared package test_checker_pkg.
REQ-020 Expected table SHALL be sub-module test_checker_exp_table (1 write port, 1 combinational read port).

Verification
REQ-021 NUM_CORES=1: load idx10=0x1, idx13=0x7ffff000, others 0; model returns same; halted at cycle 5 -> done, passed=1, fail_count=0.
REQ-022 Same load, model returns idx13=0x7ffff001 -> passed=0, fail_count=1, first_fail_index=13, exp=0x7ffff000, act=0x7ffff001.
REQ-023 halted never set, TIMEOUT_CYCLES=100 -> timed_out=1 at cycle 100, scan still runs, passed=0.
REQ-024 NUM_CORES=2, core1 idx17 wrong, idx17 care=0 -> passed=1; care=1 -> first_fail_core=1, first_fail_index=17.
REQ-025 reset low mid-SCAN at request 12 -> all outputs 0 next cycle; new start completes normally.
REQ-026 Mismatch at every index with 65540 cores×regs config -> fail_count saturates at 0xFFFF.

Source files
------------

// File: rtl/test_checker_pkg.sv
// Shared types and helpers for the register-compare test checker.
package test_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int FAIL_CNT_W = 16;

    // Ceiling log2 usable in constant expressions; CLOG2(1) = 0.
    function automatic int CLOG2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/test_checker_exp_table.sv
// Expected-value table: one entry per register index, shared by every core.
// Each entry holds {care, value}; reset leaves value 0 with care set.
module test_checker_exp_table
    import test_checker_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 32,
    localparam int IDX_W      = CLOG2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wcare_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rcare_o
);

    logic [DATA_WIDTH:0] mem_q [NUM_REGS];

    // Single write port; the whole table returns to "compare against 0" on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= {1'b1, {DATA_WIDTH{1'b0}}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= {wcare_i, wdata_i};
        end
    end

    assign rdata_o = mem_q[raddr_i][DATA_WIDTH-1:0];
    assign rcare_o = mem_q[raddr_i][DATA_WIDTH];

endmodule

// File: rtl/test_checker.sv
// Test checker: waits for all cores to halt (or a timeout), then reads back
// every register of every core and compares it against the expected table.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no test yet; expected table writable
//   RUN      | cores running, cycle counter advancing, waiting for halt
//   SCAN     | one register read request per cycle, core-major order
//   DRAIN    | last read's data returns and is compared
//   DONE     | results held until the next start; table writable
module test_checker
    import test_checker_pkg::*;
#(
    parameter int  NUM_CORES      = 1,
    parameter int  DATA_WIDTH     = 32,
    parameter int  NUM_REGS       = 32,
    parameter int  TIMEOUT_CYCLES = 100,
    localparam int CORE_W         = (NUM_CORES > 1) ? CLOG2(NUM_CORES) : 1,
    localparam int IDX_W          = CLOG2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_CORES-1:0]  halted,
    input  logic                  exp_we,
    input  logic [IDX_W-1:0]      exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  exp_care,
    output logic [CORE_W-1:0]     rd_core,
    output logic [IDX_W-1:0]      rd_index,
    output logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  passed,
    output logic                  timed_out,
    output logic [15:0]           fail_count,
    output logic [CORE_W-1:0]     first_fail_core,
    output logic [IDX_W-1:0]      first_fail_index,
    output logic [DATA_WIDTH-1:0] first_fail_exp,
    output logic [DATA_WIDTH-1:0] first_fail_act
);

    localparam int CNT_W = CLOG2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CORE_W-1:0]     CORE_LAST = CORE_W'(NUM_CORES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [FAIL_CNT_W-1:0] FAIL_MAX  = '1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cyc_q, cyc_d;
    logic [CORE_W-1:0]       core_q, core_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [CORE_W-1:0]       pend_core_q, pend_core_d;
    logic [IDX_W-1:0]        pend_idx_q, pend_idx_d;
    logic                    timed_out_q, timed_out_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CORE_W-1:0]       ff_core_q, ff_core_d;
    logic [IDX_W-1:0]        ff_idx_q, ff_idx_d;
    logic [DATA_WIDTH-1:0]   ff_exp_q, ff_exp_d;
    logic [DATA_WIDTH-1:0]   ff_act_q, ff_act_d;

    logic                    tbl_we;
    logic [DATA_WIDTH-1:0]   tbl_data;
    logic                    tbl_care;
    logic                    mismatch;
    logic                    idle_or_done;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign tbl_we       = exp_we && idle_or_done;

    // The table read port follows the outstanding request, so the entry lines
    // up with rd_data arriving one cycle after the request.
    test_checker_exp_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_exp_table (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (tbl_we),
        .waddr_i (exp_addr),
        .wdata_i (exp_data),
        .wcare_i (exp_care),
        .raddr_i (pend_idx_q),
        .rdata_o (tbl_data),
        .rcare_o (tbl_care)
    );

    // Register 0 is compared even when its care bit is cleared.
    assign mismatch = pend_q && (tbl_care || (pend_idx_q == '0)) && (rd_data != tbl_data);

    // Next-state, scan sequencing and result accumulation.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        core_d      = core_q;
        idx_d       = idx_q;
        pend_d      = 1'b0;
        pend_core_d = core_q;
        pend_idx_d  = idx_q;
        timed_out_d = timed_out_q;
        fail_cnt_d  = fail_cnt_q;
        ff_core_d   = ff_core_q;
        ff_idx_d    = ff_idx_q;
        ff_exp_d    = ff_exp_q;
        ff_act_d    = ff_act_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cyc_d       = '0;
                    core_d      = '0;
                    idx_d       = '0;
                    timed_out_d = 1'b0;
                    fail_cnt_d  = '0;
                    ff_core_d   = '0;
                    ff_idx_d    = '0;
                    ff_exp_d    = '0;
                    ff_act_d    = '0;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + CNT_W'(1);
                // A halt seen on the final allowed cycle wins over the timeout.
                if (&halted) begin
                    state_d = ST_SCAN;
                end else if (cyc_q == CNT_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                pend_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (core_q == CORE_LAST) begin
                        core_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        core_d = core_q + CORE_W'(1);
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mismatch) begin
            if (fail_cnt_q != FAIL_MAX) begin
                fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
            end
            if (fail_cnt_q == '0) begin
                ff_core_d = pend_core_q;
                ff_idx_d  = pend_idx_q;
                ff_exp_d  = tbl_data;
                ff_act_d  = rd_data;
            end
        end
    end

    // State and datapath registers; reset aborts any test in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            core_q      <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_core_q <= '0;
            pend_idx_q  <= '0;
            timed_out_q <= 1'b0;
            fail_cnt_q  <= '0;
            ff_core_q   <= '0;
            ff_idx_q    <= '0;
            ff_exp_q    <= '0;
            ff_act_q    <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            core_q      <= core_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_core_q <= pend_core_d;
            pend_idx_q  <= pend_idx_d;
            timed_out_q <= timed_out_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_core_q   <= ff_core_d;
            ff_idx_q    <= ff_idx_d;
            ff_exp_q    <= ff_exp_d;
            ff_act_q    <= ff_act_d;
        end
    end

    assign rd_valid         = (state_q == ST_SCAN);
    assign rd_core          = core_q;
    assign rd_index         = idx_q;
    assign busy             = (state_q == ST_RUN) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign passed           = done && (fail_cnt_q == '0) && !timed_out_q;
    assign timed_out        = timed_out_q;
    assign fail_count       = fail_cnt_q;
    assign first_fail_core  = ff_core_q;
    assign first_fail_index = ff_idx_q;
    assign first_fail_exp   = ff_exp_q;
    assign first_fail_act   = ff_act_q;

endmodule
